// File: rtl/branch_offset_unit_pkg.sv
// Shared constants for the branch/jump target path; decode reuses the
// extension-mode encoding so both sides agree on what in_signed means.
package branch_offset_unit_pkg;

  localparam int unsigned DEFAULT_IN_W  = 8;
  localparam int unsigned DEFAULT_OUT_W = 32;
  localparam int unsigned DEFAULT_SHIFT = 2;

  typedef enum logic {
    EXT_ZERO = 1'b0,
    EXT_SIGN = 1'b1
  } ext_mode_e;

endpackage

// File: rtl/branch_offset_unit_extend.sv
// Combinational offset extension (sign or zero) followed by a left shift
// that turns a word offset into a byte offset.
module offset_extend
  import branch_offset_unit_pkg::*;
#(
  parameter int unsigned IN_W  = DEFAULT_IN_W,
  parameter int unsigned OUT_W = DEFAULT_OUT_W,
  parameter int unsigned SHIFT = DEFAULT_SHIFT
) (
  input  logic [IN_W-1:0]  offset_i,
  input  ext_mode_e        mode_i,
  output logic [OUT_W-1:0] ext_o
);

  logic [OUT_W-1:0] wide;

  // Widen the raw field, filling the upper bits with the sign when requested.
  // The OR-mask form avoids a zero-width replication when OUT_W == IN_W.
  always_comb begin
    wide = '0;
    wide[IN_W-1:0] = offset_i;
    if (mode_i == EXT_SIGN && offset_i[IN_W-1]) begin
      wide = wide | ({OUT_W{1'b1}} << IN_W);
    end
    ext_o = wide << SHIFT;
  end

endmodule

// File: rtl/branch_offset_unit.sv
// Two-stage branch/jump target generator: stage 1 holds the extended offset
// and base PC, stage 2 holds the sum and wrap flag. Valid/ready handshake
// with back-pressure (no skid buffer) and a flush that squashes everything.
module branch_offset_unit
  import branch_offset_unit_pkg::*;
#(
  parameter int unsigned IN_W  = DEFAULT_IN_W,
  parameter int unsigned OUT_W = DEFAULT_OUT_W,
  parameter int unsigned SHIFT = DEFAULT_SHIFT
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_offset,
  input  logic             in_signed,
  input  logic [OUT_W-1:0] in_pc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_ext,
  output logic [OUT_W-1:0] out_target,
  output logic             out_wrap
);

  if (IN_W < 1) begin : g_bad_in_w
    $error("branch_offset_unit: IN_W must be at least 1");
  end
  if (OUT_W < IN_W + SHIFT) begin : g_bad_out_w
    $error("branch_offset_unit: OUT_W must be >= IN_W + SHIFT");
  end

  logic             s1_valid_q, s1_valid_d;
  logic [OUT_W-1:0] s1_ext_q, s1_ext_d;
  logic [OUT_W-1:0] s1_pc_q, s1_pc_d;
  logic             s1_signed_q, s1_signed_d;

  logic             s2_valid_q, s2_valid_d;
  logic [OUT_W-1:0] s2_ext_q, s2_ext_d;
  logic [OUT_W-1:0] s2_target_q, s2_target_d;
  logic             s2_wrap_q, s2_wrap_d;

  logic [OUT_W-1:0] ext_in;
  logic [OUT_W+1:0] sum;
  logic [1:0]       ext_hi;
  logic             s1_adv, s2_adv;

  offset_extend #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W),
    .SHIFT (SHIFT)
  ) u_extend (
    .offset_i (in_offset),
    .mode_i   (ext_mode_e'(in_signed)),
    .ext_o    (ext_in)
  );

  // Exact sum in OUT_W+2 bits. Zero-extended operands can only set bit OUT_W
  // (the carry); sign-extended ones set bit OUT_W+1 when negative, so one
  // OR of the top two bits covers both wrap rules.
  always_comb begin
    ext_hi = s1_signed_q ? {2{s1_ext_q[OUT_W-1]}} : 2'b00;
    sum    = {2'b00, s1_pc_q} + {ext_hi, s1_ext_q};
  end

  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv;

  // Next-state for both stages; flush clears valids and leaves data stale.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_ext_d    = s1_ext_q;
    s1_pc_d     = s1_pc_q;
    s1_signed_d = s1_signed_q;
    s2_valid_d  = s2_valid_q;
    s2_ext_d    = s2_ext_q;
    s2_target_d = s2_target_q;
    s2_wrap_d   = s2_wrap_q;
    if (flush) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end else begin
      if (s1_adv) begin
        s1_valid_d = in_valid;
        if (in_valid) begin
          s1_ext_d    = ext_in;
          s1_pc_d     = in_pc;
          s1_signed_d = in_signed;
        end
      end
      if (s2_adv) begin
        s2_valid_d = s1_valid_q;
        if (s1_valid_q) begin
          s2_ext_d    = s1_ext_q;
          s2_target_d = sum[OUT_W-1:0];
          s2_wrap_d   = sum[OUT_W+1] | sum[OUT_W];
        end
      end
    end
  end

  // Pipeline registers with synchronous reset to all-zero.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      s1_valid_q  <= 1'b0;
      s1_ext_q    <= '0;
      s1_pc_q     <= '0;
      s1_signed_q <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_ext_q    <= '0;
      s2_target_q <= '0;
      s2_wrap_q   <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_ext_q    <= s1_ext_d;
      s1_pc_q     <= s1_pc_d;
      s1_signed_q <= s1_signed_d;
      s2_valid_q  <= s2_valid_d;
      s2_ext_q    <= s2_ext_d;
      s2_target_q <= s2_target_d;
      s2_wrap_q   <= s2_wrap_d;
    end
  end

  assign out_valid  = s2_valid_q;
  assign out_ext    = s2_ext_q;
  assign out_target = s2_target_q;
  assign out_wrap   = s2_wrap_q;

endmodule
